// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
// instruction_fetch_stage_if
// Fetch-stage bus: control inputs, instruction memory port, IF/ID and EPC.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if;
   logic        Stall;
   logic        RedirectValid;
   logic [31:0] RedirectTarget;
   logic        RedirectIsJr;
   logic        IrqRequest;
   logic        ExceptRequest;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic [31:0] EPC;
   logic        EPCWrite;

   // master: the fetch stage itself
   modport master (
      input  Stall, RedirectValid, RedirectTarget, RedirectIsJr,
             IrqRequest, ExceptRequest, Instruction,
      output Address, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4,
             IF_ID_Valid, EPC, EPCWrite
   );

   // slave: hazard unit, decode, instruction memory
   modport slave (
      output Stall, RedirectValid, RedirectTarget, RedirectIsJr,
             IrqRequest, ExceptRequest, Instruction,
      input  Address, IF_ID_Instruction, IF_ID_PC, IF_ID_PCPlus4,
             IF_ID_Valid, EPC, EPCWrite
   );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage
// MIPS fetch stage: PC, next-PC arbitration, IF/ID register, EPC capture.
// Optional macro FETCH_IRQ_EN enables the external interrupt path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   instruction_fetch_stage_if.master  fif
);

   logic [31:0] r_pc;
   logic [31:0] r_if_id_instruction;
   logic [31:0] r_if_id_pc;
   logic [31:0] r_if_id_pcplus4;
   logic        r_if_id_valid;
   logic [31:0] r_epc;
   logic        r_epc_write;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_redirect_target;
   logic        w_irq_take;
   logic        w_trap;

   // Kernel flag survives the increment; only the low 31 bits wrap.
   assign w_pc_plus4 = {r_pc[31], r_pc[30:0] + 31'd4};

   // A register jump from user mode must not reach kernel space.
   assign w_redirect_target = (fif.RedirectIsJr && !r_pc[31])
                            ? {1'b0, fif.RedirectTarget[30:0]}
                            : fif.RedirectTarget;

`ifdef FETCH_IRQ_EN
   assign w_irq_take = fif.IrqRequest && !r_pc[31];
`else
   logic w_unused_irq;
   assign w_irq_take   = 1'b0;
   assign w_unused_irq = fif.IrqRequest ^ (^IRQ_VECTOR);
`endif

   assign w_trap = fif.ExceptRequest || w_irq_take;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc                <= RESET_PC;
         r_if_id_instruction <= 32'd0;
         r_if_id_pc          <= 32'd0;
         r_if_id_pcplus4     <= 32'd0;
         r_if_id_valid       <= 1'b0;
         r_epc               <= 32'd0;
         r_epc_write         <= 1'b0;
      end else begin
         r_epc_write <= 1'b0;
         if (w_trap || fif.RedirectValid) begin
            r_if_id_instruction <= 32'd0;
            r_if_id_pc          <= 32'd0;
            r_if_id_pcplus4     <= 32'd0;
            r_if_id_valid       <= 1'b0;
         end else if (!fif.Stall) begin
            r_if_id_instruction <= fif.Instruction;
            r_if_id_pc          <= r_pc;
            r_if_id_pcplus4     <= w_pc_plus4;
            r_if_id_valid       <= 1'b1;
         end

         if (w_trap) begin
`ifdef FETCH_IRQ_EN
            r_pc <= fif.ExceptRequest ? EXC_VECTOR : IRQ_VECTOR;
`else
            r_pc <= EXC_VECTOR;
`endif
            // Return to the oldest instruction not yet completed.
            if (fif.RedirectValid)
               r_epc <= w_redirect_target;
            else if (r_if_id_valid)
               r_epc <= r_if_id_pc;
            else
               r_epc <= r_pc;
            r_epc_write <= 1'b1;
         end else if (fif.RedirectValid) begin
            r_pc <= w_redirect_target;
         end else if (!fif.Stall) begin
            r_pc <= w_pc_plus4;
         end
      end
   end

   assign fif.Address           = r_pc;
   assign fif.IF_ID_Instruction = r_if_id_instruction;
   assign fif.IF_ID_PC          = r_if_id_pc;
   assign fif.IF_ID_PCPlus4     = r_if_id_pcplus4;
   assign fif.IF_ID_Valid       = r_if_id_valid;
   assign fif.EPC               = r_epc;
   assign fif.EPCWrite          = r_epc_write;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// tb_instruction_fetch_stage
// Directed self-checking bench for instruction_fetch_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   instruction_fetch_stage_if fif ();

   instruction_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fif.Stall          = 1'b0;
      fif.RedirectValid  = 1'b0;
      fif.RedirectTarget = 32'd0;
      fif.RedirectIsJr   = 1'b0;
      fif.IrqRequest     = 1'b0;
      fif.ExceptRequest  = 1'b0;
   endtask

   task automatic redirect_to(input logic [31:0] tgt);
      fif.RedirectValid  = 1'b1;
      fif.RedirectTarget = tgt;
      step();
      idle_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      idle_inputs();
      fif.Instruction = 32'h2004_0000;
      step();
      step();

      check_eq("rst_addr",  fif.Address, 32'h8000_0000);
      check_eq("rst_valid", {31'd0, fif.IF_ID_Valid}, 32'd0);
      check_eq("rst_ifpc",  fif.IF_ID_PC, 32'd0);
      check_eq("rst_instr", fif.IF_ID_Instruction, 32'd0);
      check_eq("rst_epc",   fif.EPC, 32'd0);
      check_eq("rst_epcw",  {31'd0, fif.EPCWrite}, 32'd0);

      // Free-running fetch from the reset vector
      reset = 1'b0;
      check_eq("run0_addr", fif.Address, 32'h8000_0000);
      step();
      check_eq("run1_addr",  fif.Address, 32'h8000_0004);
      check_eq("run1_valid", {31'd0, fif.IF_ID_Valid}, 32'd1);
      check_eq("run1_ifpc",  fif.IF_ID_PC, 32'h8000_0000);
      check_eq("run1_pc4",   fif.IF_ID_PCPlus4, 32'h8000_0004);
      check_eq("run1_instr", fif.IF_ID_Instruction, 32'h2004_0000);
      step();
      check_eq("run2_addr", fif.Address, 32'h8000_0008);
      step();
      check_eq("run3_addr", fif.Address, 32'h8000_000C);
      check_eq("run3_pc4",  fif.IF_ID_PCPlus4, 32'h8000_000C);

      // Redirect into user space, then stall three cycles at 0x1C
      redirect_to(32'h0000_0018);
      check_eq("redir_addr",  fif.Address, 32'h0000_0018);
      check_eq("redir_valid", {31'd0, fif.IF_ID_Valid}, 32'd0);
      check_eq("redir_ifpc",  fif.IF_ID_PC, 32'd0);
      fif.Instruction = 32'h1111_1111;
      step();
      check_eq("pre_stall_addr", fif.Address, 32'h0000_001C);
      fif.Instruction = 32'h2222_2222;
      fif.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall_addr",  fif.Address, 32'h0000_001C);
         check_eq("stall_ifpc",  fif.IF_ID_PC, 32'h0000_0018);
         check_eq("stall_instr", fif.IF_ID_Instruction, 32'h1111_1111);
         check_eq("stall_valid", {31'd0, fif.IF_ID_Valid}, 32'd1);
      end
      fif.Stall = 1'b0;
      step();
      check_eq("unstall_addr",  fif.Address, 32'h0000_0020);
      check_eq("unstall_ifpc",  fif.IF_ID_PC, 32'h0000_001C);
      check_eq("unstall_instr", fif.IF_ID_Instruction, 32'h2222_2222);

      // Redirect overrides Stall
      fif.Stall = 1'b1;
      redirect_to(32'h0000_006C);
      check_eq("rs_addr",  fif.Address, 32'h0000_006C);
      check_eq("rs_valid", {31'd0, fif.IF_ID_Valid}, 32'd0);
      step();
      check_eq("rs_next_addr", fif.Address, 32'h0000_0070);
      check_eq("rs_next_ifpc", fif.IF_ID_PC, 32'h0000_006C);
      check_eq("rs_next_valid", {31'd0, fif.IF_ID_Valid}, 32'd1);

      // jr from user mode cannot set the kernel bit
      redirect_to(32'h0000_0040);
      check_eq("pre_jr_addr", fif.Address, 32'h0000_0040);
      fif.RedirectIsJr = 1'b1;
      redirect_to(32'h8000_0010);
      check_eq("jr_user_addr", fif.Address, 32'h0000_0010);

      // Interrupt at PC=0x30 with IF_ID_PC=0x2C valid
      redirect_to(32'h0000_002C);
      step();
      check_eq("pre_irq_ifpc", fif.IF_ID_PC, 32'h0000_002C);
      fif.IrqRequest = 1'b1;
      step();
`ifdef FETCH_IRQ_EN
      check_eq("irq_addr",  fif.Address, 32'h8000_0004);
      check_eq("irq_epc",   fif.EPC, 32'h0000_002C);
      check_eq("irq_epcw",  {31'd0, fif.EPCWrite}, 32'd1);
      check_eq("irq_valid", {31'd0, fif.IF_ID_Valid}, 32'd0);
      step();
      check_eq("irq_held_addr", fif.Address, 32'h8000_0008);
      check_eq("irq_held_epcw", {31'd0, fif.EPCWrite}, 32'd0);
      step();
      check_eq("irq_held2_addr", fif.Address, 32'h8000_000C);
      check_eq("irq_held2_epc",  fif.EPC, 32'h0000_002C);
`else
      check_eq("noirq_addr", fif.Address, 32'h0000_0034);
      check_eq("noirq_epcw", {31'd0, fif.EPCWrite}, 32'd0);
      check_eq("noirq_epc",  fif.EPC, 32'd0);
      step();
      check_eq("noirq2_addr", fif.Address, 32'h0000_0038);
`endif
      fif.IrqRequest = 1'b0;

      // Kernel-mode jr keeps the kernel bit
      redirect_to(32'h8000_0100);
      fif.RedirectIsJr = 1'b1;
      redirect_to(32'h8000_0010);
      check_eq("jr_kern_addr", fif.Address, 32'h8000_0010);

      // Exception and interrupt together from user mode
      redirect_to(32'h0000_0050);
      step();
      fif.ExceptRequest = 1'b1;
      fif.IrqRequest    = 1'b1;
      step();
      idle_inputs();
      check_eq("exc_addr", fif.Address, 32'h8000_0008);
      check_eq("exc_epc",  fif.EPC, 32'h0000_0050);
      check_eq("exc_epcw", {31'd0, fif.EPCWrite}, 32'd1);
      step();
      check_eq("exc_next_addr", fif.Address, 32'h8000_000C);
      check_eq("exc_next_epcw", {31'd0, fif.EPCWrite}, 32'd0);
      check_eq("exc_next_epc",  fif.EPC, 32'h0000_0050);

      // Exception with same-cycle redirect: EPC takes the redirect target
      fif.ExceptRequest  = 1'b1;
      fif.RedirectValid  = 1'b1;
      fif.RedirectTarget = 32'h0000_0300;
      step();
      idle_inputs();
      check_eq("excr_addr", fif.Address, 32'h8000_0008);
      check_eq("excr_epc",  fif.EPC, 32'h0000_0300);

      // Exception with IF/ID holding a bubble: EPC takes PC
      fif.ExceptRequest = 1'b1;
      step();
      idle_inputs();
      check_eq("excb_epc",  fif.EPC, 32'h8000_0008);
      check_eq("excb_epcw", {31'd0, fif.EPCWrite}, 32'd1);

      // Low 31 bits wrap while the kernel bit is preserved
      redirect_to(32'hFFFF_FFFC);
      step();
      check_eq("wrapk_addr", fif.Address, 32'h8000_0000);
      check_eq("wrapk_pc4",  fif.IF_ID_PCPlus4, 32'h8000_0000);
      redirect_to(32'h7FFF_FFFC);
      step();
      check_eq("wrapu_addr", fif.Address, 32'h0000_0000);

      // Reset wins over a pending stall and redirect
      fif.Stall          = 1'b1;
      fif.RedirectValid  = 1'b1;
      fif.RedirectTarget = 32'h0000_0400;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_inputs();
      check_eq("rst2_addr",  fif.Address, 32'h8000_0000);
      check_eq("rst2_valid", {31'd0, fif.IF_ID_Valid}, 32'd0);
      check_eq("rst2_epc",   fif.EPC, 32'd0);
      check_eq("rst2_ifpc",  fif.IF_ID_PC, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
